// File: rtl/fpu_result_uart_tx.sv
// FPU result readback: buffers completed 32-bit results in a FIFO and sends each word as
// 8N1 UART bytes, MSB byte first. Define FPU_RESULT_TX_HDR_EN to send a 0xA5 header per word.
module fpu_result_uart_tx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      clks_per_bit,
  input  logic             result_valid,
  input  logic [31:0]      result_data,
  output logic             o_Tx_Serial,
  output logic             tx_busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FPU_RESULT_TX_HDR_EN
  localparam int unsigned NumBytes = 5;
`else
  localparam int unsigned NumBytes = 4;
`endif
  localparam int unsigned ShW      = NumBytes * 8;
  localparam logic [2:0]  LastByte = 3'(NumBytes - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             empty, full, push, pop;

  state_e           state_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = (state_q == StIdle) && !empty;
  // A pop in the same cycle frees the head slot, so a push at full still lands.
  assign push  = result_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= result_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (result_valid && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  logic [ShW-1:0] shift_q;
  logic [15:0]    period_q;
  logic [15:0]    cnt_q;
  logic [2:0]     bit_q;
  logic [2:0]     byte_q;
  logic           tx_q;
  logic           busy_q;

  logic [15:0]    period_sel;
  logic           bit_end;
  logic [7:0]     cur_byte;
  logic [ShW-1:0] load_word;

  assign period_sel = (clks_per_bit == 16'd0) ? 16'd1 : clks_per_bit;
  assign bit_end    = (cnt_q == period_q - 16'd1);
  assign cur_byte   = shift_q[ShW-1 -: 8];
`ifdef FPU_RESULT_TX_HDR_EN
  assign load_word  = {8'hA5, mem_q[rd_ptr_q]};
`else
  assign load_word  = mem_q[rd_ptr_q];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      period_q <= 16'd1;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            shift_q  <= load_word;
            byte_q   <= '0;
            period_q <= period_sel;
            cnt_q    <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (byte_q == LastByte) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              byte_q  <= byte_q + 3'd1;
              shift_q <= shift_q << 8;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_Tx_Serial = tx_q;
  assign tx_busy     = busy_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed bench for fpu_result_uart_tx: frame timing, FIFO fill/overflow, reset abort,
// minimum bit period. Expected frames are built from the pushed words.
module tb_fpu_result_uart_tx;

`ifdef FPU_RESULT_TX_HDR_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clks_per_bit;
  logic        result_valid;
  logic [31:0] result_data;
  logic        o_Tx_Serial;
  logic        tx_busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  fpu_result_uart_tx #(
    .DEPTH(4),
    .CNT_W(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clks_per_bit (clks_per_bit),
    .result_valid (result_valid),
    .result_data  (result_data),
    .o_Tx_Serial  (o_Tx_Serial),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] wbyte(input logic [31:0] w, input int i);
`ifdef FPU_RESULT_TX_HDR_EN
    if (i == 0) return 8'hA5;
    return w[8*(4-i) +: 8];
`else
    return w[8*(3-i) +: 8];
`endif
  endfunction

  // Entered 1ns after the edge that starts the word's first start bit, offset by skip cycles.
  // Leaves 1ns after the edge that returns the FSM to idle.
  task automatic check_word(input logic [31:0] w, input int period, input int skip);
    int   total;
    int   j;
    int   pos;
    logic [7:0] b;
    logic exp_bit;
    total = NB * 10 * period;
    for (int k = skip; k < total; k++) begin
      j   = k / period;
      pos = j % 10;
      b   = wbyte(w, j / 10);
      if (pos == 0)      exp_bit = 1'b0;
      else if (pos == 9) exp_bit = 1'b1;
      else               exp_bit = b[pos-1];
      chk($sformatf("line w=%h k=%0d", w, k), {31'b0, o_Tx_Serial}, {31'b0, exp_bit});
      chk($sformatf("busy w=%h k=%0d", w, k), {31'b0, tx_busy}, 32'd1);
      tick();
    end
    chk($sformatf("end busy w=%h", w), {31'b0, tx_busy}, 32'd0);
    chk($sformatf("end line w=%h", w), {31'b0, o_Tx_Serial}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    clks_per_bit = 16'd4;
    result_valid = 1'b0;
    result_data  = '0;
    tick();
    tick();
    chk("rst line", {31'b0, o_Tx_Serial}, 32'd1);
    chk("rst busy", {31'b0, tx_busy}, 32'd0);
    chk("rst count", {29'b0, fifo_count}, 32'd0);
    chk("rst ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // Single word: write at k, start bit from k+1.
    result_valid = 1'b1;
    result_data  = 32'h3F80_0000;
    tick();
    result_valid = 1'b0;
    chk("single count after push", {29'b0, fifo_count}, 32'd1);
    chk("single line before pop", {31'b0, o_Tx_Serial}, 32'd1);
    chk("single busy before pop", {31'b0, tx_busy}, 32'd0);
    tick();
    chk("single count after pop", {29'b0, fifo_count}, 32'd0);
    check_word(32'h3F80_0000, 4, 0);

    // Burst of 5: first goes to the shifter, four stay buffered.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      result_valid = 1'b1;
      result_data  = 32'(i);
      tick();
    end
    result_valid = 1'b0;
    chk("burst count", {29'b0, fifo_count}, 32'd4);
    chk("burst ovf", {31'b0, overflow}, 32'd0);
    check_word(32'd1, 4, 3);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("burst count pop %0d", i), {29'b0, fifo_count}, 32'(5 - i));
      check_word(32'(i), 4, 0);
    end

    // Push/pop at full, then overflow with the shifter busy.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      result_valid = 1'b1;
      result_data  = 32'hA000_0000 + 32'(i);
      tick();
    end
    result_valid = 1'b0;
    chk("full count", {29'b0, fifo_count}, 32'd4);
    for (int i = 0; i < 157; i++) tick();
    chk("full idle busy", {31'b0, tx_busy}, 32'd0);
    chk("full idle count", {29'b0, fifo_count}, 32'd4);
    result_valid = 1'b1;
    result_data  = 32'hA000_0005;
    tick();
    chk("pushpop count", {29'b0, fifo_count}, 32'd4);
    chk("pushpop ovf", {31'b0, overflow}, 32'd0);
    chk("pushpop busy", {31'b0, tx_busy}, 32'd1);
    result_data = 32'hA000_0006;
    tick();
    result_valid = 1'b0;
    chk("ovf set", {31'b0, overflow}, 32'd1);
    chk("ovf count", {29'b0, fifo_count}, 32'd4);
    check_word(32'hA000_0001, 4, 1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_word(32'hA000_0000 + 32'(i), 4, 0);
    end
    tick();
    chk("ovf sticky", {31'b0, overflow}, 32'd1);
    chk("drained busy", {31'b0, tx_busy}, 32'd0);
    chk("drained count", {29'b0, fifo_count}, 32'd0);
    do_reset();
    chk("ovf cleared", {31'b0, overflow}, 32'd0);

    // Reset during the data bits of byte 1 aborts the frame and drops the buffered word.
    result_valid = 1'b1;
    result_data  = 32'h1234_5678;
    tick();
    result_data  = 32'h5555_AAAA;
    tick();
    result_valid = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("mid busy", {31'b0, tx_busy}, 32'd1);
    chk("mid count", {29'b0, fifo_count}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort line", {31'b0, o_Tx_Serial}, 32'd1);
    chk("abort busy", {31'b0, tx_busy}, 32'd0);
    chk("abort count", {29'b0, fifo_count}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("abort quiet line", {31'b0, o_Tx_Serial}, 32'd1);
    chk("abort quiet busy", {31'b0, tx_busy}, 32'd0);
    result_valid = 1'b1;
    result_data  = 32'hDEAD_BEEF;
    tick();
    result_valid = 1'b0;
    tick();
    check_word(32'hDEAD_BEEF, 4, 0);

    // Zero period behaves as one; a period change mid-word is ignored until the next word.
    do_reset();
    clks_per_bit = 16'd0;
    result_valid = 1'b1;
    result_data  = 32'h4049_0FDB;
    tick();
    result_valid = 1'b0;
    tick();
    clks_per_bit = 16'd4;
    check_word(32'h4049_0FDB, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
